// File: rtl/life_pkg.sv
// life_pkg: shared definitions for the Game-of-Life grid engine.
//   state_t       - engine FSM states (SEED only used by the LFSR seeding build)
//   RGB_*         - packed {red, green, blue} colour constants, 2 bits each
//   LFSR_*        - Galois LFSR taps and seed for the random-seed build
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_COMMIT,
    ST_SEED
  } state_t;

  localparam logic [5:0] RGB_BLANK  = 6'b00_00_00;
  localparam logic [5:0] RGB_BORDER = 6'b11_01_01;
  localparam logic [5:0] RGB_LIVE   = 6'b00_00_00;
  localparam logic [5:0] RGB_DEAD   = 6'b11_11_11;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/life_rule.sv
// life_rule: combinational B3/S23 cell update.
//   nbrs   [7:0] in  - the eight neighbour cells
//   centre       in  - current state of the cell itself
//   alive        out - state of the cell in the next generation
module life_rule (
  input  logic [7:0] nbrs,
  input  logic       centre,
  output logic       alive
);

  logic [3:0] count;

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      count = count + {3'b000, nbrs[i]};
    end
    alive = (count == 4'd3) | (centre & (count == 4'd2));
  end

endmodule

// File: rtl/life_grid_engine.sv
// life_grid_engine: Conway's Game of Life on a toroidal GRID_W x GRID_H grid,
// rendered as square cells of 2^CELL_LOG2 pixels on a 640x480 raster.
//   clk          in  - pixel clock
//   reset        in  - synchronous, active-high
//   hpos, vpos   in  - current pixel column / row
//   frame_tick   in  - one pulse per frame (start of vertical blank)
//   run          in  - 1: advance one generation every FRAMES_PER_GEN frames
//   step         in  - single-generation request while paused and idle
//   red/green/blue out - registered pixel colour, 1 clock after hpos/vpos
//   busy         out - a generation (or seeding) is in progress
//   gen_count    out - completed generations, wrapping
// Build option: define LIFE_LFSR_SEED_EN to seed the grid from a 16-bit LFSR
// after reset instead of loading a glider.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int GRID_W         = 24,
  parameter int GRID_H         = 24,
  parameter int CELL_LOG2      = 4,
  parameter int FRAMES_PER_GEN = 60,
  parameter int H_ORIGIN       = (640 - GRID_W * (2 ** CELL_LOG2)) / 2,
  parameter int V_ORIGIN       = (480 - GRID_H * (2 ** CELL_LOG2)) / 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        frame_tick,
  input  logic        run,
  input  logic        step,
  output logic [1:0]  red,
  output logic [1:0]  green,
  output logic [1:0]  blue,
  output logic        busy,
  output logic [15:0] gen_count
);

  localparam int CW = $clog2(GRID_W);
  localparam int RW = $clog2(GRID_H);
  localparam int WIN_W = GRID_W << CELL_LOG2;
  localparam int WIN_H = GRID_H << CELL_LOG2;
  localparam logic [CW-1:0] COL_LAST = CW'(GRID_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(GRID_H - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAMES_PER_GEN - 1);

  logic [GRID_H-1:0][GRID_W-1:0] cur;
  logic [GRID_H-1:0][GRID_W-1:0] nxt;

  state_t state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [15:0]   frame_cnt;
  logic          frame_wrap;
  logic          trig;
  logic          last_cell;

`ifdef LIFE_LFSR_SEED_EN
  logic [15:0] lfsr;
`endif

  // ---------------- neighbour fetch and rule ----------------
  logic [CW-1:0] cm, cp;
  logic [RW-1:0] rm, rp;
  logic [7:0]    nbrs;
  logic          cell_next;

  always_comb begin
    cm = (col == '0) ? COL_LAST : col - 1'b1;
    cp = (col == COL_LAST) ? '0 : col + 1'b1;
    rm = (row == '0) ? ROW_LAST : row - 1'b1;
    rp = (row == ROW_LAST) ? '0 : row + 1'b1;
    nbrs = {cur[rm][cm], cur[rm][col], cur[rm][cp],
            cur[row][cm],              cur[row][cp],
            cur[rp][cm], cur[rp][col], cur[rp][cp]};
  end

  life_rule u_rule (
    .nbrs   (nbrs),
    .centre (cur[row][col]),
    .alive  (cell_next)
  );

  // ---------------- FSM ----------------
  always_comb begin
    frame_wrap = run && frame_tick && (frame_cnt == FRAME_LAST);
    trig       = run ? frame_wrap : step;
    last_cell  = (col == COL_LAST) && (row == ROW_LAST);
    state_nxt  = state;
    case (state)
      ST_IDLE:   if (trig) state_nxt = ST_CALC;
      ST_CALC:   if (last_cell) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      ST_SEED:   if (last_cell) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // col/row wrap back to 0 after the last cell, so they are already zero
  // whenever a new pass (CALC or SEED) begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      gen_count <= '0;
      frame_cnt <= '0;
      nxt       <= '0;
`ifdef LIFE_LFSR_SEED_EN
      state     <= ST_SEED;
      lfsr      <= LFSR_SEED;
      cur       <= '0;
`else
      state     <= ST_IDLE;
      cur       <= '0;
      cur[0][1] <= 1'b1;
      cur[1][2] <= 1'b1;
      cur[2][0] <= 1'b1;
      cur[2][1] <= 1'b1;
      cur[2][2] <= 1'b1;
`endif
    end else begin
      state <= state_nxt;

      // Frame counter keeps running while busy; a wrap then simply loses its trigger.
      if (!run) begin
        frame_cnt <= '0;
      end else if (frame_tick) begin
        frame_cnt <= frame_wrap ? '0 : frame_cnt + 16'd1;
      end

      if (state == ST_CALC || state == ST_SEED) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      case (state)
        ST_CALC:   nxt[row][col] <= cell_next;
        ST_COMMIT: begin
          cur       <= nxt;
          gen_count <= gen_count + 16'd1;
        end
`ifdef LIFE_LFSR_SEED_EN
        ST_SEED: begin
          cur[row][col] <= lfsr[0];
          lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
`endif
        default: ;
      endcase
    end
  end

  // ---------------- pixel colour ----------------
  logic [9:0]    dx, dy;
  logic [CW-1:0] pcol;
  logic [RW-1:0] prow;
  logic          in_win;
  logic          cell_live;
  logic [5:0]    rgb_q;

  always_comb begin
    dx        = hpos - 10'(H_ORIGIN);
    dy        = vpos - 10'(V_ORIGIN);
    pcol      = CW'(dx >> CELL_LOG2);
    prow      = RW'(dy >> CELL_LOG2);
    in_win    = (int'(hpos) >= H_ORIGIN) && (int'(hpos) < H_ORIGIN + WIN_W) &&
                (int'(vpos) >= V_ORIGIN) && (int'(vpos) < V_ORIGIN + WIN_H);
    cell_live = cur[prow][pcol];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= RGB_BLANK;
    end else if (hpos >= 10'd640 || vpos >= 10'd480) begin
      rgb_q <= RGB_BLANK;
    end else if (!in_win) begin
      rgb_q <= RGB_BORDER;
    end else if (cell_live) begin
      rgb_q <= RGB_LIVE;
    end else begin
      rgb_q <= RGB_DEAD;
    end
  end

  assign {red, green, blue} = rgb_q;

endmodule

// File: tb/tb_life_grid_engine.sv
module tb_life_grid_engine;

  typedef logic [31:0][31:0] grid_t;  // [row][col], only the used corner matters

  localparam int W = 24, H = 24, HO = 128, VO = 48, CS = 16;
  localparam int SW = 6, SH = 5, SHO = 296, SVO = 220, SCS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (defaults)
  logic        reset = 1'b1, run = 1'b0, step = 1'b0, frame_tick = 1'b0;
  logic [9:0]  hpos = '0, vpos = '0;
  logic [1:0]  red, green, blue;
  logic        busy;
  logic [15:0] gen_count;

  life_grid_engine dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .frame_tick(frame_tick),
    .run(run), .step(step), .red(red), .green(green), .blue(blue),
    .busy(busy), .gen_count(gen_count)
  );

  // small instance: tight torus, so wrap-around is exercised constantly
  logic        s_reset = 1'b1, s_step = 1'b0;
  logic        s_run = 1'b0, s_tick_in = 1'b0;
  logic [9:0]  s_hpos = '0, s_vpos = '0;
  logic [1:0]  s_red, s_green, s_blue;
  logic        s_busy;
  logic [15:0] s_gen;

  life_grid_engine #(.GRID_W(SW), .GRID_H(SH), .CELL_LOG2(3), .FRAMES_PER_GEN(2)) dut_s (
    .clk(clk), .reset(s_reset), .hpos(s_hpos), .vpos(s_vpos), .frame_tick(s_tick_in),
    .run(s_run), .step(s_step), .red(s_red), .green(s_green), .blue(s_blue),
    .busy(s_busy), .gen_count(s_gen)
  );

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_grid(input string name, input grid_t act, input grid_t exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic grid_t glider();
    grid_t g = '0;
    g[0][1] = 1'b1; g[1][2] = 1'b1; g[2][0] = 1'b1; g[2][1] = 1'b1; g[2][2] = 1'b1;
    return g;
  endfunction

  function automatic grid_t life_next(input grid_t g, input int w, input int h);
    grid_t nx = '0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) n += int'(g[(r + dr + h) % h][(c + dc + w) % w]);
        nx[r][c] = (n == 3) || (g[r][c] && n == 2);
      end
    return nx;
  endfunction

  function automatic logic [5:0] exp_colour(input int hp, input int vp, input grid_t g,
                                            input int w, input int h, input int ho,
                                            input int vo, input int cs);
    if (hp >= 640 || vp >= 480) return 6'b000000;
    if (hp < ho || hp >= ho + w * cs || vp < vo || vp >= vo + h * cs) return 6'b110101;
    return g[(vp - vo) / cs][(hp - ho) / cs] ? 6'b000000 : 6'b111111;
  endfunction

  grid_t      mcur;
  int         rem = 0, ticks = 0, mgen = 0;
  logic [5:0] exp_rgb;
  logic       exp_busy;

  // One clock of the main DUT: drive, advance model, compare after the edge.
  task automatic tick(input logic rst, input logic r, input logic s, input logic ft,
                      input logic [9:0] h, input logic [9:0] v);
    logic fire, trig;
    reset = rst; run = r; step = s; frame_tick = ft; hpos = h; vpos = v;
    if (rst) begin
      exp_rgb = '0; mcur = glider(); rem = 0; mgen = 0; ticks = 0;
    end else begin
      exp_rgb = exp_colour(int'(h), int'(v), mcur, W, H, HO, VO, CS);
      fire = 1'b0;
      if (!r) ticks = 0;
      else if (ft) begin
        ticks++;
        if (ticks == 60) begin ticks = 0; fire = 1'b1; end
      end
      trig = r ? fire : s;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin mcur = life_next(mcur, W, H); mgen++; end
      end else if (trig) rem = W * H + 1;
    end
    exp_busy = (rem > 0);
    @(posedge clk);
    @(negedge clk);
    check("rgb", int'({red, green, blue}), int'(exp_rgb));
    check("busy", int'(busy), int'(exp_busy));
    check("gen_count", int'(gen_count), mgen & 16'hFFFF);
  endtask

  task automatic rnd_pix(output logic [9:0] h, output logic [9:0] v);
    if ($urandom_range(0, 3) == 0) begin
      h = 10'($urandom_range(0, 1023));
      v = 10'($urandom_range(0, 1023));
    end else begin
      h = 10'(HO + $urandom_range(0, W * CS - 1));
      v = 10'(VO + $urandom_range(0, H * CS - 1));
    end
  endtask

  task automatic idle(input int n, input logic r);
    logic [9:0] h, v;
    for (int i = 0; i < n; i++) begin
      rnd_pix(h, v);
      tick(1'b0, r, 1'b0, 1'b0, h, v);
    end
  endtask

  task automatic wait_idle(input logic r);
    int k = 0;
    while (busy && k < 3000) begin
      idle(1, r);
      k++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic scan_main(output grid_t g);
    g = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        tick(1'b0, 1'b0, 1'b0, 1'b0, 10'(HO + c * CS + 8), 10'(VO + r * CS + 8));
        g[r][c] = ({red, green, blue} == 6'd0);
      end
  endtask

  task automatic s_tick(input logic rst, input logic st, input logic [9:0] h,
                        input logic [9:0] v);
    s_reset = rst; s_step = st; s_hpos = h; s_vpos = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    grid_t g, lit, b;
    logic [9:0] h, v;
    logic rr, ss, ff;
    int n, g0;

    @(negedge clk);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 10'd200, 10'd100);
    check("reset_rgb", int'({red, green, blue}), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_gen", int'(gen_count), 0);

    // colour literals on the seed glider
    tick(1'b0, 1'b0, 1'b0, 1'b0, 10'(HO + 16), 10'(VO));
    check("rgb_live_1_0", int'({red, green, blue}), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    check("rgb_border", int'({red, green, blue}), 6'b110101);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 10'd700, 10'd0);
    check("rgb_blank", int'({red, green, blue}), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 10'(HO), 10'(VO));
    check("rgb_dead_0_0", int'({red, green, blue}), 6'b111111);

    // single step of the glider
    tick(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      idle(1, 1'b0);
    end
    check("step_busy_len", n, 577);
    check("step_gen", int'(gen_count), 1);
    lit = '0;
    lit[1][0] = 1'b1; lit[1][2] = 1'b1; lit[2][1] = 1'b1; lit[2][2] = 1'b1; lit[3][1] = 1'b1;
    check_grid("model_gen1", mcur, lit);
    scan_main(g);
    check_grid("dut_gen1", g, lit);

    // horizontal blinker across the right edge becomes vertical in column 0
    b = '0;
    b[5][W-1] = 1'b1; b[5][0] = 1'b1; b[5][1] = 1'b1;
    lit = '0;
    lit[4][0] = 1'b1; lit[5][0] = 1'b1; lit[6][0] = 1'b1;
    check_grid("model_blinker_wrap", life_next(b, W, H), lit);

    // step while busy is dropped
    g0 = mgen;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
    idle(5, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
    wait_idle(1'b0);
    idle(3, 1'b0);
    check("step_while_busy", int'(gen_count), g0 + 1);

    // run mode: 120 frame ticks, 20 clocks apart
    g0 = mgen;
    for (int t = 1; t <= 120; t++) begin
      idle(19, 1'b1);
      rnd_pix(h, v);
      tick(1'b0, 1'b1, 1'b0, 1'b1, h, v);
      if (t == 59 || t == 119) check("busy_before_60th", int'(busy), 0);
      if (t == 60 || t == 120) check("trigger_on_60th", int'(busy), 1);
    end
    wait_idle(1'b1);
    idle(2, 1'b0);
    check("run_two_gens", int'(gen_count), g0 + 2);

    // random traffic: run chunks, stray steps, dense frame ticks (some lost while busy)
    rr = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 149) == 0) rr = ~rr;
      ss = ($urandom_range(0, 199) == 0);
      ff = rr && ($urandom_range(0, 3) == 0);
      rnd_pix(h, v);
      tick(1'b0, rr, ss, ff, h, v);
    end
    wait_idle(1'b0);

    // reset at clock 100 of CALC abandons the generation
    tick(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
    idle(99, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    check("midcalc_reset_busy", int'(busy), 0);
    check("midcalc_reset_gen", int'(gen_count), 0);
    scan_main(g);
    check_grid("midcalc_reset_seed", g, glider());

    // small torus: glider repeatedly crosses the wrap edges
    s_tick(1'b1, 1'b0, 10'd0, 10'd0);
    s_tick(1'b1, 1'b0, 10'd0, 10'd0);
    b = glider();
    for (int gi = 1; gi <= 15; gi++) begin
      s_tick(1'b0, 1'b1, 10'd0, 10'd0);
      n = 0;
      while (s_busy && n < 200) begin
        n++;
        s_tick(1'b0, 1'b0, 10'd0, 10'd0);
      end
      if (gi == 1) check("small_busy_len", n, SW * SH + 1);
      check("small_gen", int'(s_gen), gi);
      b = life_next(b, SW, SH);
      g = '0;
      for (int r = 0; r < SH; r++)
        for (int c = 0; c < SW; c++) begin
          s_tick(1'b0, 1'b0, 10'(SHO + c * SCS + 4), 10'(SVO + r * SCS + 4));
          g[r][c] = ({s_red, s_green, s_blue} == 6'd0);
        end
      check_grid("small_grid", g, b);
    end
    s_tick(1'b0, 1'b0, 10'(SHO - 1), 10'(SVO));
    check("small_border", int'({s_red, s_green, s_blue}), 6'b110101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
